// File: rtl/pg_top.sv
// pg_top: pattern generator replaying host-written 16-bit words on pins at a programmable tick rate.
module pg_top #(
  parameter int         width = 32,
  parameter logic [2:0] ADDR  = 3'd1,
  parameter int         DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [width-1:0]         packet_in,
  input  logic                     packet_valid,
  output logic                     packet_ready,
  output logic [15:0]              pin_vals,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     running,
  output logic                     underrun,
  output logic                     fmt_err
);
  localparam int AW = $clog2(DEPTH);
  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [23:0]   period, cnt;
  logic          acc, hit, cfg_p, flush, push, bad, empty, tick, pop;
  logic          unused_rsvd;
  assign unused_rsvd = packet_in[25];
  assign running = period != '0;
  always_comb begin
    packet_ready = fifo_count != (AW+1)'(DEPTH);
    acc          = packet_valid & packet_ready;
    hit          = acc && packet_in[31:29] == ADDR;
    cfg_p        = hit & packet_in[28];
    flush        = cfg_p & packet_in[24];
    push         = hit & !packet_in[28] & (packet_in[27:26] == 2'd2);
    bad          = hit & !packet_in[28] & (packet_in[27:26] != 2'd2);
    empty        = fifo_count == '0;
    tick         = running && cnt == period;
    // a flush in the same cycle discards the head instead of replaying it
    pop          = tick & !empty & !flush;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      period     <= '0;
      cnt        <= '0;
      underrun   <= 1'b0;
      fmt_err    <= 1'b0;
      wptr       <= '0;
      rptr       <= '0;
      fifo_count <= '0;
      pin_vals   <= '0;
    end else begin
      if (cfg_p) begin
        period   <= packet_in[23:0];
        cnt      <= '0;
        underrun <= 1'b0;
        fmt_err  <= 1'b0;
      end else begin
        cnt <= (!running || tick) ? '0 : cnt + 24'd1;
        if (tick & empty) underrun <= 1'b1;
        if (bad) fmt_err <= 1'b1;
      end
      if (flush) begin
        wptr       <= '0;
        rptr       <= '0;
        fifo_count <= '0;
      end else begin
        if (push) wptr <= wptr + 1'b1;
        if (pop) begin
          rptr     <= rptr + 1'b1;
          pin_vals <= mem[rptr];
        end
        fifo_count <= fifo_count + (AW+1)'(push) - (AW+1)'(pop);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= packet_in[15:0];
  end
endmodule

// File: tb/tb_pg_top.sv
// tb_pg_top: table-driven and sequence checks of pg_top with a replay scoreboard on pin_vals.
module tb_pg_top;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] packet_in = '0;
  logic        packet_valid = 1'b0;
  logic        packet_ready;
  logic [15:0] pin_vals;
  logic [4:0]  fifo_count;
  logic        running, underrun, fmt_err;
  pg_top dut (
    .clk(clk), .rst(rst), .packet_in(packet_in), .packet_valid(packet_valid),
    .packet_ready(packet_ready), .pin_vals(pin_vals), .fifo_count(fifo_count),
    .running(running), .underrun(underrun), .fmt_err(fmt_err)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [31:0] pkt;
    int          cnt;
    logic        fe;
    logic        run;
  } vec_t;
  vec_t        tbl [9];
  logic [15:0] exp_q [$];
  int          chg [$];
  logic [15:0] prev = '0;
  logic [15:0] held;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  function automatic logic [31:0] mk(input logic [2:0] a, input logic c, input logic [1:0] nb,
                                     input logic fl, input logic [23:0] d);
    return {a, c, nb, 1'b0, fl, d};
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask
  // advance one clock; every pin_vals change must be the next word the scoreboard expects
  task automatic step();
    @(negedge clk);
    cyc++;
    if (rst && pin_vals !== prev) begin
      if (exp_q.size() == 0) chk("pin_unexpected", {16'h0, pin_vals}, {16'h0, prev});
      else chk("pin_vals", {16'h0, pin_vals}, {16'h0, exp_q.pop_front()});
      chg.push_back(cyc);
    end
    prev = pin_vals;
  endtask
  task automatic send(input logic [31:0] p, input int lim);
    bit done = 0;
    packet_in    = p;
    packet_valid = 1'b1;
    for (int i = 0; i < lim && !done; i++) begin
      done = packet_ready;
      step();
    end
    packet_valid = 1'b0;
    if (!done) chk("send_timeout", 32'h0, 32'h1);
    else if (p[31:29] == 3'd1 && !p[28] && p[27:26] == 2'd2) exp_q.push_back(p[15:0]);
    else if (p[31:29] == 3'd1 && p[28] && p[24]) exp_q.delete();
  endtask
  initial begin
    tbl[0] = '{mk(3'd1, 0, 2'd2, 0, 24'h1111), 1, 0, 0};
    tbl[1] = '{mk(3'd2, 0, 2'd2, 0, 24'h7777), 1, 0, 0};
    tbl[2] = '{mk(3'd1, 0, 2'd1, 0, 24'h8888), 1, 1, 0};
    tbl[3] = '{mk(3'd1, 0, 2'd3, 0, 24'h9999), 1, 1, 0};
    tbl[4] = '{mk(3'd1, 0, 2'd2, 0, 24'h2222), 2, 1, 0};
    tbl[5] = '{mk(3'd3, 1, 2'd0, 1, 24'd5),    2, 1, 0};
    tbl[6] = '{mk(3'd1, 1, 2'd0, 0, 24'd0),    2, 0, 0};
    tbl[7] = '{mk(3'd1, 0, 2'd0, 0, 24'h3333), 2, 1, 0};
    tbl[8] = '{mk(3'd1, 1, 2'd0, 1, 24'd0),    0, 0, 0};
    // reset held with traffic offered
    packet_in    = mk(3'd1, 0, 2'd2, 0, 24'hDEAD);
    packet_valid = 1'b1;
    repeat (3) step();
    chk("rst_pin", {16'h0, pin_vals}, 32'h0);
    chk("rst_count", {27'h0, fifo_count}, 32'h0);
    chk("rst_running", {31'h0, running}, 32'h0);
    chk("rst_underrun", {31'h0, underrun}, 32'h0);
    chk("rst_fmt_err", {31'h0, fmt_err}, 32'h0);
    packet_valid = 1'b0;
    rst = 1'b1;
    step();
    chk("rst_ready", {31'h0, packet_ready}, 32'h1);
    chk("rst_count_after", {27'h0, fifo_count}, 32'h0);
    // filter / format / config table
    for (int i = 0; i < 9; i++) begin
      send(tbl[i].pkt, 10);
      chk($sformatf("tbl%0d_count", i), {27'h0, fifo_count}, tbl[i].cnt);
      chk($sformatf("tbl%0d_fmt_err", i), {31'h0, fmt_err}, {31'h0, tbl[i].fe});
      chk($sformatf("tbl%0d_running", i), {31'h0, running}, {31'h0, tbl[i].run});
    end
    chk("tbl_pin", {16'h0, pin_vals}, 32'h0);
    // replay at period 3: two words 4 clocks apart, then underrun
    chg.delete();
    send(mk(3'd1, 1, 2'd0, 1, 24'd3), 10);
    send(mk(3'd1, 0, 2'd2, 0, 24'hA5A5), 10);
    send(mk(3'd1, 0, 2'd2, 0, 24'h5A5A), 10);
    chk("replay_underrun0", {31'h0, underrun}, 32'h0);
    repeat (12) step();
    chk("replay_changes", chg.size(), 2);
    if (chg.size() >= 2) chk("replay_gap", chg[1] - chg[0], 4);
    chk("replay_pin", {16'h0, pin_vals}, 32'h5A5A);
    chk("replay_underrun1", {31'h0, underrun}, 32'h1);
    chk("replay_drained", exp_q.size(), 0);
    // full: long period so the FIFO fills before the first tick
    send(mk(3'd1, 1, 2'd0, 1, 24'd200), 10);
    chk("full_underrun_clr", {31'h0, underrun}, 32'h0);
    for (int i = 0; i < 16; i++) send(mk(3'd1, 0, 2'd2, 0, 24'h1000 + i), 10);
    chk("full_ready", {31'h0, packet_ready}, 32'h0);
    chk("full_count", {27'h0, fifo_count}, 32'd16);
    packet_in    = mk(3'd1, 0, 2'd2, 0, 24'h2000);
    packet_valid = 1'b1;
    repeat (3) step();
    chk("full_hold_count", {27'h0, fifo_count}, 32'd16);
    send(mk(3'd1, 0, 2'd2, 0, 24'h2000), 300);
    chk("full_first_pop", {16'h0, pin_vals}, 32'h1000);
    chk("full_refill", {27'h0, fifo_count}, 32'd16);
    send(mk(3'd1, 1, 2'd0, 1, 24'd0), 300);
    chk("full_flushed", {27'h0, fifo_count}, 32'h0);
    // flush with 5 words buffered
    for (int i = 0; i < 5; i++) send(mk(3'd1, 0, 2'd2, 0, 24'h3000 + i), 10);
    chk("flush_pre_count", {27'h0, fifo_count}, 32'd5);
    held = pin_vals;
    send(mk(3'd1, 1, 2'd0, 1, 24'd10), 10);
    chk("flush_count", {27'h0, fifo_count}, 32'h0);
    chk("flush_pin_held", {16'h0, pin_vals}, {16'h0, held});
    chk("flush_running", {31'h0, running}, 32'h1);
    send(mk(3'd1, 0, 2'd2, 0, 24'hBEEF), 10);
    repeat (15) step();
    chk("flush_replay_pin", {16'h0, pin_vals}, 32'hBEEF);
    // push lands on the tick while one word is buffered
    send(mk(3'd1, 1, 2'd0, 1, 24'd3), 10);
    send(mk(3'd1, 0, 2'd2, 0, 24'h4001), 10);
    repeat (2) step();
    send(mk(3'd1, 0, 2'd2, 0, 24'h4002), 10);
    chk("pot_count", {27'h0, fifo_count}, 32'd1);
    chk("pot_pin", {16'h0, pin_vals}, 32'h4001);
    chk("pot_underrun", {31'h0, underrun}, 32'h0);
    repeat (6) step();
    chk("pot_pin2", {16'h0, pin_vals}, 32'h4002);
    chk("pot_drained", exp_q.size(), 0);
    // asynchronous reset in the middle of a replay
    send(mk(3'd1, 1, 2'd0, 0, 24'd2), 10);
    for (int i = 0; i < 3; i++) send(mk(3'd1, 0, 2'd2, 0, 24'h5001 + i), 10);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_pin", {16'h0, pin_vals}, 32'h0);
    chk("arst_count", {27'h0, fifo_count}, 32'h0);
    chk("arst_running", {31'h0, running}, 32'h0);
    chk("arst_ready", {31'h0, packet_ready}, 32'h1);
    exp_q.delete();
    step();
    rst = 1'b1;
    repeat (5) step();
    chk("arst_idle_pin", {16'h0, pin_vals}, 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
